// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared state encoding and default bus widths for the ROM reader and the address display.
package rom_reader_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HANDOFF, DONE} state_t;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/rom_access_timer.sv
// rom_access_timer: loadable down-counter with a zero flag that times the ROM output-enable window.
module rom_access_timer #(
    parameter int ACCESS_CYCLES = 4,
    localparam int W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam logic [W-1:0] LOAD_VAL = W'(ACCESS_CYCLES - 1);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = load ? LOAD_VAL : (en && count_q != '0) ? count_q - W'(1) : count_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    assign zero = (count_q == '0);
endmodule

// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: walks every ROM address, times CE/OE for each access and hands
// each captured byte downstream over a valid/ready handshake.
module rom_read_sequencer
    import rom_reader_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ACCESS_CYCLES = 4,
    parameter int END_ADDR      = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  data_ready,
    output logic [ADDR_WIDTH-1:0] address_line,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(END_ADDR);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic load, zero;
    rom_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .en   (state_q == ACCESS),
        .zero (zero)
    );
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        valid_d = valid_q;
        load    = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = SETUP;
                addr_d  = '0;
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b1;
            end
            SETUP: begin
                state_d = ACCESS;
                oe_n_d  = 1'b0;
                load    = 1'b1;
            end
            ACCESS: if (zero) begin
                state_d = HANDOFF;
                dout_d  = rom_data;
                valid_d = 1'b1;
                oe_n_d  = 1'b1;
            end
            HANDOFF: if (valid_q && data_ready) begin
                valid_d = 1'b0;
                state_d = (addr_q == LAST) ? DONE : SETUP;
                ce_n_d  = (addr_q == LAST);
                addr_d  = (addr_q == LAST) ? addr_q : addr_q + ADDR_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
        // Abort outranks start and any same-cycle handshake; the pending byte is dropped.
        if (abort) begin
            state_d = (state_q == DONE) ? DONE : IDLE;
            addr_d  = addr_q;
            dout_d  = dout_q;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            valid_d = 1'b0;
        end
        busy_d = state_d inside {SETUP, ACCESS, HANDOFF};
        done_d = (state_d == DONE);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    assign address_line = addr_q;
    assign rom_ce_n     = ce_n_q;
    assign rom_oe_n     = oe_n_q;
    assign data_out     = dout_q;
    assign data_valid   = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer: directed scenarios with a per-cycle reference monitor for two
// instances (ACCESS_CYCLES=4 full 512-byte dump, ACCESS_CYCLES=1 short dump).
module tb_rom_read_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rf(input logic [8:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // instance 0: ACCESS_CYCLES=4, full address range
    logic start, abort, data_ready, ce_n, oe_n, valid, busy, done;
    logic [8:0] addr;
    logic [7:0] dout, rom_data;
    int oe_cnt0;
    always @(posedge clk or negedge reset)
        if (!reset) oe_cnt0 <= 0;
        else        oe_cnt0 <= oe_n ? 0 : oe_cnt0 + 1;
    // the ROM only drives good data once the access time has elapsed
    assign rom_data = (!oe_n && oe_cnt0 == 3) ? rf(addr) : 8'h00;

    rom_read_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .rom_data(rom_data),
        .data_ready(data_ready), .address_line(addr), .rom_ce_n(ce_n), .rom_oe_n(oe_n),
        .data_out(dout), .data_valid(valid), .busy(busy), .done(done)
    );

    // instance 1: ACCESS_CYCLES=1, addresses 0..15
    logic start1, ce1, oe1, valid1, busy1, done1;
    logic [8:0] addr1;
    logic [7:0] dout1, rom1;
    int oe_cnt1;
    always @(posedge clk or negedge reset)
        if (!reset) oe_cnt1 <= 0;
        else        oe_cnt1 <= oe1 ? 0 : oe_cnt1 + 1;
    assign rom1 = (!oe1 && oe_cnt1 == 0) ? rf(addr1) : 8'h00;

    rom_read_sequencer #(.ACCESS_CYCLES(1), .END_ADDR(15)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .rom_data(rom1),
        .data_ready(1'b1), .address_line(addr1), .rom_ce_n(ce1), .rom_oe_n(oe1),
        .data_out(dout1), .data_valid(valid1), .busy(busy1), .done(done1)
    );

    // reference monitor for instance 0
    int run0 = 0, hs0 = 0, last_rise = -1;
    bit cut0 = 0, pv0 = 0, tp_en = 0;
    logic [7:0] pd0 = '0;
    logic [8:0] exp0 = '0;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            run0 = 0; cut0 = 0; pv0 = 0;
        end else begin
            if (!oe_n) begin
                chk("oe_inside_ce", ce_n, 0);
                run0++;
                if (abort) cut0 = 1;
            end else if (run0 != 0) begin
                if (!cut0) chk("oe_low_cycles", run0, 4);
                run0 = 0; cut0 = 0;
            end
            if (start && !abort && !busy) exp0 = 0;
            if (valid) begin
                chk("byte_value", dout, rf(addr));
                chk("byte_addr", addr, exp0);
                if (pv0) chk("dout_stable", dout, pd0);
            end
            if (valid && !pv0) begin
                if (tp_en && last_rise >= 0) chk("byte_period", cyc - last_rise, 6);
                last_rise = cyc;
            end
            if (valid && data_ready && !abort) begin
                hs0++;
                if (exp0 != 511) exp0++;
            end
            pv0 = valid; pd0 = dout;
        end
    end

    // reference monitor for instance 1
    int run1 = 0, hs1 = 0, last1 = -1;
    bit pv1 = 0;
    logic [8:0] exp1 = '0;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            run1 = 0; pv1 = 0; last1 = -1;
        end else begin
            if (!oe1) begin
                chk("oe1_inside_ce", ce1, 0);
                run1++;
            end else if (run1 != 0) begin
                chk("oe1_low_cycles", run1, 1);
                run1 = 0;
            end
            if (start1 && !busy1) exp1 = 0;
            if (valid1) begin
                chk("byte1_value", dout1, rf(addr1));
                chk("byte1_addr", addr1, exp1);
            end
            if (valid1 && !pv1) begin
                if (last1 >= 0) chk("byte1_period", cyc - last1, 3);
                last1 = cyc;
            end
            if (valid1) begin
                hs1++;
                if (exp1 != 15) exp1++;
            end
            pv1 = valid1;
        end
    end

    int t0;
    task automatic pulse_start();
        @(posedge clk); #1 start = 1; t0 = cyc;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_ce_n"}, ce_n, 1);
        chk({tag, "_oe_n"}, oe_n, 1);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        reset = 0; start = 0; abort = 0; data_ready = 1; start1 = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        reset = 1;
        repeat (2) @(posedge clk);

        // 1: full dump with ready high
        hs0 = 0; last_rise = -1; tp_en = 1;
        pulse_start();
        chk("setup_addr", addr, 0);
        chk("setup_ce_n", ce_n, 0);
        chk("setup_oe_n", oe_n, 1);
        for (int i = 0; i < 20 && !valid; i++) begin @(posedge clk); #1; end
        chk("first_valid_latency", cyc - t0, 6);
        chk("first_byte", dout, 8'hA5);
        for (int i = 0; i < 4000 && !done; i++) begin @(posedge clk); #1; end
        tp_en = 0;
        chk("dump_done", done, 1);
        chk("bytes_dumped", hs0, 512);
        chk("done_addr", addr, 511);
        chk("done_busy", busy, 0);
        chk("done_ce_n", ce_n, 1);
        repeat (3) @(posedge clk);
        #1 chk("done_addr_holds", addr, 511);

        // 2: backpressure at address 3
        pulse_start();
        chk("restart_done_flag", done, 0);
        for (int i = 0; i < 100 && !(valid && addr == 3); i++) begin @(posedge clk); #1; end
        chk("reach_addr3", addr, 3);
        data_ready = 0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid", valid, 1);
            chk("bp_dout", dout, 8'hA6);
            chk("bp_ce_n", ce_n, 0);
            chk("bp_addr", addr, 3);
        end
        data_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", valid, 0);
        chk("bp_release_addr", addr, 4);

        // 3: abort during ACCESS of address 7
        for (int i = 0; i < 100 && !(addr == 7 && !oe_n); i++) begin @(posedge clk); #1; end
        chk("reach_access7", oe_n, 0);
        abort = 1;
        @(posedge clk); #1 abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_ce_n", ce_n, 1);
        chk("abort_oe_n", oe_n, 1);
        chk("abort_valid", valid, 0);
        chk("abort_addr", addr, 7);
        repeat (4) @(posedge clk);
        #1 chk("idle_addr_holds", addr, 7);
        pulse_start();
        chk("restart_addr", addr, 0);
        chk("restart_busy", busy, 1);

        // 4: start while busy at address 20
        for (int i = 0; i < 200 && !(addr == 20 && !oe_n); i++) begin @(posedge clk); #1; end
        pulse_start();
        chk("busy_start_addr", addr, 20);
        for (int i = 0; i < 40 && !(valid && addr == 21); i++) begin @(posedge clk); #1; end
        chk("after_busy_start_addr", addr, 21);
        chk("after_busy_start_byte", dout, 8'hB0);

        // 5: asynchronous reset in HANDOFF
        data_ready = 0;
        for (int i = 0; i < 20 && !valid; i++) begin @(posedge clk); #1; end
        chk("in_handoff", valid, 1);
        #2 reset = 0;
        #1 chk_reset_vals("async_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1; data_ready = 1;
        repeat (8) @(posedge clk);
        #1 chk_reset_vals("post_reset_idle");

        // 6: ACCESS_CYCLES=1 instance
        hs1 = 0;
        @(posedge clk); #1 start1 = 1; t0 = cyc;
        @(posedge clk); #1 start1 = 0;
        for (int i = 0; i < 10 && !valid1; i++) begin @(posedge clk); #1; end
        chk("ac1_first_latency", cyc - t0, 3);
        for (int i = 0; i < 200 && !done1; i++) begin @(posedge clk); #1; end
        chk("ac1_done", done1, 1);
        chk("ac1_bytes", hs1, 16);
        chk("ac1_end_addr", addr1, 15);
        chk("ac1_last_byte", dout1, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
